// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch slice: buffer entry layout, fetch FSM states
// and architectural constants.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with single-cycle flush; push and pop may
// occur together (a push into a full FIFO is accepted only alongside a pop).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  wdata,
  input  logic          pop,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited in-order imem requests, response buffer and redirect flush.
// Optional build macro FETCH_MISALIGN_CHECK_EN: misaligned redirects raise fetch_fault and halt fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e    state_r, state_n;
  logic            fault_r, fault_n;
  logic [XLEN-1:0] pc_r, pc_n;
  logic [CW-1:0]   outstanding_r, outstanding_n;
  logic [CW-1:0]   discard_r, discard_n;

  fetch_entry_t    ib_wdata, ib_rdata;
  logic [CW-1:0]   ib_count;
  logic            ib_full, ib_empty, ib_push;
  fetch_entry_t    pcq_wdata, pcq_rdata;
  logic [CW-1:0]   pcq_count;
  logic            pcq_full, pcq_empty;

  logic            req_fire, rsp_take, inst_fire, redir_ok;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redir_tgt;

  assign redir_tgt = {redirect_pc[XLEN-1:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_ok  = (redirect_pc[1:0] == 2'b00);
`else
  assign redir_ok  = 1'b1;
`endif

  // A head consumed this cycle frees its slot, which keeps depth-2 streaming at one per cycle.
  assign inst_fire      = inst_valid && inst_ready;
  assign credit_used    = {1'b0, outstanding_r} + {1'b0, ib_count} - {{CW{1'b0}}, inst_fire};
  assign imem_req_valid = !reset && (state_r == RUN) && !redirect_valid &&
                          (credit_used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_r;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding belong to requests issued before reset.
  assign rsp_take = imem_rsp_valid && (outstanding_r != '0);
  assign ib_push  = rsp_take && (discard_r == '0) && !redirect_valid;

  assign pcq_wdata = '{pc: pc_r, inst: NOP_INST};
  assign ib_wdata  = '{pc: pcq_rdata.pc, inst: imem_rsp_data};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pcq (
    .clk   (clk),
    .reset (reset),
    .flush (1'b0),
    .push  (req_fire),
    .wdata (pcq_wdata),
    .pop   (rsp_take),
    .rdata (pcq_rdata),
    .count (pcq_count),
    .full  (pcq_full),
    .empty (pcq_empty)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (ib_push),
    .wdata (ib_wdata),
    .pop   (inst_fire),
    .rdata (ib_rdata),
    .count (ib_count),
    .full  (ib_full),
    .empty (ib_empty)
  );

  assign inst_valid  = !ib_empty;
  assign inst_data   = ib_empty ? '0 : ib_rdata.inst;
  assign inst_pc     = ib_empty ? '0 : ib_rdata.pc;
  assign fetch_fault = fault_r;

  always_comb begin
    state_n       = state_r;
    fault_n       = fault_r;
    pc_n          = pc_r;
    outstanding_n = outstanding_r + CW'(req_fire) - CW'(rsp_take);
    discard_n     = discard_r;
    if (redirect_valid) begin
      // Every request still in flight after this edge returns a stale word.
      discard_n = outstanding_n;
      if (redir_ok) pc_n = redir_tgt;
`ifdef FETCH_MISALIGN_CHECK_EN
      state_n = redir_ok ? RUN : HALT;
      fault_n = !redir_ok;
`endif
    end else begin
      if (req_fire) pc_n = pc_r + XLEN'(INSTR_BYTES);
      if (rsp_take && (discard_r != '0)) discard_n = discard_r - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= RUN;
      fault_r       <= 1'b0;
      pc_r          <= RESET_PC;
      outstanding_r <= '0;
      discard_r     <= '0;
    end else begin
      state_r       <= state_n;
      fault_r       <= fault_n;
      pc_r          <= pc_n;
      outstanding_r <= outstanding_n;
      discard_r     <= discard_n;
    end
  end

  logic unused_sig;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign unused_sig = ^{ib_full, pcq_full, pcq_empty, pcq_count, pcq_rdata.inst};
`else
  assign unused_sig = ^{ib_full, pcq_full, pcq_empty, pcq_count, pcq_rdata.inst, redirect_pc[1:0]};
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: instruction-stream model plus a 1-cycle instruction memory.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 2;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  int          passed = 0;
  int          total  = 0;
  logic [31:0] memq [$];
  logic [31:0] seen [$];
  logic [31:0] exp_pc;
  bit          halted, mem_hold, rst_drv;
  int          issued, consumed;
  logic        last_rsp, last_fire, last_ivalid, last_req_valid;
  logic [31:0] last_req_addr;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[7:0], 24'h0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    total++;
    if (act <= lim) passed++;
    else $display("FAIL %s: got %0d, expected at most %0d", name, act, lim);
  endtask

  task automatic check_seen(input string name, input int idx, input logic [31:0] req);
    if (seen.size() > idx) check(name, seen[idx], req);
    else check(name, 32'hDEAD_BEEF, req);
  endtask

  // One clock: drive at the falling edge, observe after settling, handshakes land on the next rising edge.
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    reset          = rst_drv;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = 1'b1;
    if (!reset && !mem_hold && memq.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    last_rsp       = imem_rsp_valid;
    last_fire      = inst_valid && inst_ready;
    last_ivalid    = inst_valid;
    last_req_valid = imem_req_valid;
    last_req_addr  = imem_req_addr;
    if (reset) begin
      memq.delete();
      halted = 1'b0;
      exp_pc = 32'h0;
    end else begin
      check("fetch_fault", {31'h0, fetch_fault}, {31'h0, halted});
      if (imem_req_valid && imem_req_ready) begin
        memq.push_back(imem_req_addr);
        issued++;
      end
      check_le("mem_inflight", memq.size(), DEPTH);
      if (halted) begin
        check("halt_quiet", {30'h0, inst_valid, imem_req_valid}, 32'h0);
      end else if (inst_valid && inst_ready) begin
        check("inst_pc", inst_pc, exp_pc);
        check("inst_data", inst_data, word_of(exp_pc));
        seen.push_back(inst_pc);
        exp_pc += 32'd4;
        consumed++;
      end
      if (rv) begin
        seen.delete();
        if (EN && rpc[1:0] != 2'b00) halted = 1'b1;
        else begin
          halted = 1'b0;
          exp_pc = {rpc[31:2], 2'b00};
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1; rst_drv = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    exp_pc = '0; halted = 1'b0; mem_hold = 1'b0; issued = 0; consumed = 0;

    // Reset state
    repeat (3) cycle(1'b0, 1'b0, 32'h0);
    check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_fault", {31'h0, fetch_fault}, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    rst_drv = 1'b0;

    // 1: streaming, one instruction per cycle once the pipe is full
    cycle(1'b1, 1'b0, 32'h0);
    check("first_req_valid", {31'h0, last_req_valid}, 32'h1);
    check("first_req_addr", last_req_addr, 32'h0);
    repeat (3) cycle(1'b1, 1'b0, 32'h0);
    base = consumed;
    repeat (16) cycle(1'b1, 1'b0, 32'h0);
    check("stream_rate", consumed - base, 16);
    check_seen("stream_pc0", 0, 32'h0);
    check_seen("stream_pc1", 1, 32'h4);
    check_seen("stream_pc2", 2, 32'h8);

    // 2: consumer stalls, credits bound outstanding+buffered
    repeat (10) begin
      cycle(1'b0, 1'b0, 32'h0);
      check_le("credit_bound", issued - consumed, DEPTH);
    end
    check("stall_filled", issued - consumed, DEPTH);
    check("stall_valid", {31'h0, last_ivalid}, 32'h1);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);

    // 3: redirect with two requests in flight
    mem_hold = 1'b1;
    repeat (4) cycle(1'b1, 1'b0, 32'h0);
    check("inflight_two", memq.size(), 2);
    cycle(1'b1, 1'b1, 32'h0000_0100);
    mem_hold = 1'b0;
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
    check_seen("redir_pc0", 0, 32'h0000_0100);
    check_seen("redir_pc1", 1, 32'h0000_0104);

    // 4: redirect coinciding with a response and a consumed head
    cycle(1'b1, 1'b1, 32'h0000_0200);
    check("coincide_rsp", {31'h0, last_rsp}, 32'h1);
    check("coincide_fire", {31'h0, last_fire}, 32'h1);
    cycle(1'b1, 1'b0, 32'h0);
    check("flushed_empty", {31'h0, last_ivalid}, 32'h0);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
    check_seen("post_flush_pc", 0, 32'h0000_0200);

    // 5: PC wraps at the top of the address space
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
    check_seen("wrap_pc0", 0, 32'hFFFF_FFFC);
    check_seen("wrap_pc1", 1, 32'h0000_0000);

`ifdef FETCH_MISALIGN_CHECK_EN
    // 6: misaligned redirect halts fetch until an aligned one arrives
    cycle(1'b1, 1'b1, 32'h0000_0102);
    repeat (5) cycle(1'b1, 1'b0, 32'h0);
    check("fault_set", {31'h0, fetch_fault}, 32'h1);
    check("halt_no_req", {31'h0, last_req_valid}, 32'h0);
    cycle(1'b1, 1'b1, 32'h0000_0200);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
    check("fault_clear", {31'h0, fetch_fault}, 32'h0);
    check_seen("resume_pc", 0, 32'h0000_0200);
`else
    // Low address bits of a redirect are ignored
    cycle(1'b1, 1'b1, 32'h0000_0102);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
    check_seen("align_pc", 0, 32'h0000_0100);
    check("no_fault", {31'h0, fetch_fault}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
